// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-bus controller: MIO_EN/R handshake onto an async SRAM with programmable wait states.
// Optional switch/hex-display I/O decode at IO_ADDR when LC3_MEM_MMIO_EN is defined.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  output logic              R,
  output logic [15:0]       MDR_In,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic [15:0]       Data_to_SRAM,
  output logic              Data_drive_en,
  input  logic [15:0]       Data_from_SRAM,
  input  logic [15:0]       S,
  output logic [15:0]       HEX_Out
);

  typedef enum logic [2:0] {IDLE, ACCESS, DONE, RELEASE, IO} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       wr;

`ifdef LC3_MEM_MMIO_EN
  logic [15:0] hex;
  assign HEX_Out = hex;
`else
  assign HEX_Out = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wr            <= 1'b0;
      R             <= 1'b0;
      MDR_In        <= '0;
      ADDR          <= '0;
      CE_N          <= 1'b1;
      OE_N          <= 1'b1;
      WE_N          <= 1'b1;
      Data_to_SRAM  <= '0;
      Data_drive_en <= 1'b0;
`ifdef LC3_MEM_MMIO_EN
      hex           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          R <= 1'b0;
          if (MIO_EN) begin
            ADDR         <= ADDR_W'(MAR);
            wr           <= R_W;
            Data_to_SRAM <= MDR;
            cnt          <= 4'(WAIT_CYCLES);
            // The I/O location bypasses the SRAM strobes entirely.
`ifdef LC3_MEM_MMIO_EN
            if (MAR == IO_ADDR) state <= IO;
            else
`endif
            begin
              state         <= ACCESS;
              CE_N          <= 1'b0;
              OE_N          <= R_W;
              WE_N          <= ~R_W;
              Data_drive_en <= R_W;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!wr) MDR_In <= Data_from_SRAM;
            state         <= DONE;
            R             <= 1'b1;
            OE_N          <= 1'b1;
            WE_N          <= 1'b1;
            // Writes keep CE_N and the bus driver for one extra cycle of data hold.
            CE_N          <= ~wr;
            Data_drive_en <= wr;
          end
        end
        DONE: begin
          R             <= 1'b0;
          CE_N          <= 1'b1;
          Data_drive_en <= 1'b0;
          state         <= MIO_EN ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!MIO_EN) state <= IDLE;
        end
`ifdef LC3_MEM_MMIO_EN
        IO: begin
          if (wr) hex <= Data_to_SRAM;
          else    MDR_In <= S;
          R     <= 1'b1;
          state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl with a small async SRAM model that enforces a minimum WE_N pulse width.
// Define LC3_MEM_MMIO_EN for both bench and RTL to exercise the I/O decode.
module tb_lc3_mem_ctrl;
  localparam int unsigned WAIT = 2;

  logic        clk = 1'b0;
  logic        reset, mio_en, r_w;
  logic [15:0] mar, mdr, s, data_from_sram;
  logic        r, ce_n, oe_n, we_n, drive_en;
  logic [15:0] mdr_in, data_to_sram, hex_out;
  logic [19:0] addr;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [15:0] mem [0:1023];
  int unsigned wcnt = 0;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  int unsigned r_count, oe_count, we_count;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(20), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(reset), .MIO_EN(mio_en), .R_W(r_w), .MAR(mar), .MDR(mdr),
    .R(r), .MDR_In(mdr_in), .ADDR(addr), .CE_N(ce_n), .OE_N(oe_n), .WE_N(we_n),
    .Data_to_SRAM(data_to_sram), .Data_drive_en(drive_en),
    .Data_from_SRAM(data_from_sram), .S(s), .HEX_Out(hex_out)
  );

  assign data_from_sram = (ce_n === 1'b0 && oe_n === 1'b0) ? mem[addr[9:0]] : 16'h0000;

  // SRAM write commits on WE_N rising only if the pulse lasted at least WAIT cycles.
  always @(negedge clk) begin
    if (we_n === 1'b0 && ce_n === 1'b0) begin
      wcnt  = wcnt + 1;
      waddr = addr[9:0];
      wdata = data_to_sram;
    end else begin
      if (wcnt >= WAIT) mem[waddr] = wdata;
      wcnt = 0;
    end
  end

  // Bus invariants, checked mid-cycle.
  always @(negedge clk) begin
    vectors++;
    assert ((oe_n | we_n) !== 1'b0) else begin
      miscompares++;
      $error("FAIL oe_we_overlap: OE_N=%b WE_N=%b expected not both 0", oe_n, we_n);
    end
    vectors++;
    assert ((drive_en & ~oe_n) !== 1'b1) else begin
      miscompares++;
      $error("FAIL drive_on_read: Data_drive_en=%b OE_N=%b expected not both active", drive_en, oe_n);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_R"}, {31'd0, r}, 32'd0);
    chk({tag, "_strobes"}, {29'd0, ce_n, oe_n, we_n}, 32'd7);
    chk({tag, "_drive"}, {31'd0, drive_en}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h000] = 16'hBEEF;   // backs 0x3000
    mem[10'h010] = 16'h5A5A;   // prior contents of 0x0010
    reset = 1'b1; mio_en = 1'b0; r_w = 1'b0; mar = '0; mdr = '0; s = 16'h00A5;

    step(); step();
    reset = 1'b0;
    chk("rst_mdr_in", {16'd0, mdr_in}, 32'd0);
    chk("rst_addr", {12'd0, addr}, 32'd0);
    chk("rst_data_to_sram", {16'd0, data_to_sram}, 32'd0);
    chk("rst_hex", {16'd0, hex_out}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("idle");
      chk("idle_mdr_in", {16'd0, mdr_in}, 32'd0);
    end

    // Read 0x3000: cycle 0 request, R in cycle 3.
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
    step();  // cycle 1
    chk("rd_c1_addr", {12'd0, addr}, 32'h03000);
    chk("rd_c1_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b001);
    chk("rd_c1_R", {31'd0, r}, 32'd0);
    step();  // cycle 2
    chk("rd_c2_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b001);
    chk("rd_c2_R", {31'd0, r}, 32'd0);
    step();  // cycle 3
    chk("rd_c3_R", {31'd0, r}, 32'd1);
    chk("rd_c3_mdr_in", {16'd0, mdr_in}, 32'hBEEF);
    chk("rd_c3_oe", {31'd0, oe_n}, 32'd1);
    mio_en = 1'b0;
    step();  // cycle 4: IDLE
    chk_idle("rd_c4");

    // Back-to-back write 0x0042 <= 0x1234; later MDR/MAR changes must be ignored.
    mio_en = 1'b1; r_w = 1'b1; mar = 16'h0042; mdr = 16'h1234;
    step();  // cycle 1
    mdr = 16'hFFFF; mar = 16'h0777; r_w = 1'b0;
    chk("wr_c1_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b010);
    chk("wr_c1_drive", {31'd0, drive_en}, 32'd1);
    chk("wr_c1_data", {16'd0, data_to_sram}, 32'h1234);
    chk("wr_c1_addr", {12'd0, addr}, 32'h00042);
    step();  // cycle 2
    chk("wr_c2_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b010);
    chk("wr_c2_data", {16'd0, data_to_sram}, 32'h1234);
    chk("wr_c2_R", {31'd0, r}, 32'd0);
    step();  // cycle 3: data hold
    chk("wr_c3_R", {31'd0, r}, 32'd1);
    chk("wr_c3_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b011);
    chk("wr_c3_drive", {31'd0, drive_en}, 32'd1);
    chk("wr_c3_data", {16'd0, data_to_sram}, 32'h1234);
    mio_en = 1'b0;
    step();  // cycle 4
    chk_idle("wr_c4");
    chk("wr_addr_hold", {12'd0, addr}, 32'h00042);
    step();
    chk("wr_mem", {16'd0, mem[10'h042]}, 32'h1234);
    chk("rd_mdr_in_held", {16'd0, mdr_in}, 32'hBEEF);

    // Held request: read 0x3000, MIO_EN high until 6 cycles after R.
    r_count = 0; oe_count = 0; we_count = 0;
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h3000;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (r === 1'b1) r_count++;
      if (oe_n === 1'b0) oe_count++;
      if (we_n === 1'b0) we_count++;
      if (c >= 4) chk_idle("hold_release");
    end
    chk("hold_r_count", r_count, 32'd1);
    chk("hold_oe_count", oe_count, 32'd2);
    chk("hold_we_count", we_count, 32'd0);
    mio_en = 1'b0;   // dropped in cycle 9
    step();          // cycle 10 must be IDLE: a request here is accepted at once
    mio_en = 1'b1; mar = 16'h0042;
    step();
    chk("rerq_c1_ce_oe", {29'd0, ce_n, oe_n, we_n}, 32'b001);
    mio_en = 1'b0;   // drop during ACCESS: access still completes
    mar = 16'h3000;
    step();
    chk("drop_c2_R", {31'd0, r}, 32'd0);
    step();
    chk("drop_c3_R", {31'd0, r}, 32'd1);
    chk("drop_c3_mdr_in", {16'd0, mdr_in}, 32'h1234);
    step();
    chk_idle("drop_c4");

    // Reset asserted in cycle 1 of a write to 0x0010.
    mio_en = 1'b1; r_w = 1'b1; mar = 16'h0010; mdr = 16'hDEAD;
    step();  // cycle 1
    chk("rstw_c1_we", {31'd0, we_n}, 32'd0);
    reset = 1'b1;
    step();  // cycle 2
    reset = 1'b0; mio_en = 1'b0;
    chk_idle("rstw_c2");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rstw_after");
    end
    mio_en = 1'b1; r_w = 1'b0; mar = 16'h0010;
    step(); step(); step();
    chk("rstw_rd_R", {31'd0, r}, 32'd1);
    chk("rstw_rd_data", {16'd0, mdr_in}, 32'h5A5A);
    mio_en = 1'b0;
    step();

`ifdef LC3_MEM_MMIO_EN
    // I/O read of switches: R in cycle 2, SRAM untouched.
    mio_en = 1'b1; r_w = 1'b0; mar = 16'hFFFF; s = 16'h00A5;
    step();  // cycle 1
    chk_idle("io_rd_c1");
    step();  // cycle 2
    chk("io_rd_R", {31'd0, r}, 32'd1);
    chk("io_rd_mdr_in", {16'd0, mdr_in}, 32'h00A5);
    chk("io_rd_ce", {31'd0, ce_n}, 32'd1);
    mio_en = 1'b0;
    step();
    mio_en = 1'b1; r_w = 1'b1; mar = 16'hFFFF; mdr = 16'h0C3D;
    step();
    chk_idle("io_wr_c1");
    step();
    chk("io_wr_R", {31'd0, r}, 32'd1);
    chk("io_wr_hex", {16'd0, hex_out}, 32'h0C3D);
    chk("io_wr_ce", {31'd0, ce_n}, 32'd1);
    mio_en = 1'b0;
    step();
    chk_idle("io_wr_c3");
`else
    // Without the decode, 0xFFFF is ordinary SRAM and HEX_Out stays 0.
    mio_en = 1'b1; r_w = 1'b1; mar = 16'hFFFF; mdr = 16'h0C3D;
    step();
    chk("noio_c1_ce_oe_we", {29'd0, ce_n, oe_n, we_n}, 32'b010);
    step(); step();
    chk("noio_R", {31'd0, r}, 32'd1);
    chk("noio_hex", {16'd0, hex_out}, 32'd0);
    mio_en = 1'b0;
    step(); step();
    chk("noio_mem", {16'd0, mem[10'h3FF]}, 32'h0C3D);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory-bus controller between the LC-3 control unit / MAR-MDR datapath and the off-chip SRAM.
- Accepts one access request per MIO_EN assertion and runs the SRAM chip-enable, output-enable and write-enable sequence with configurable wait states.
- Returns a one-cycle ready strobe R plus registered read data for MDR.
- Replaces the fixed nR1/nR2 padding states in the control unit with a real handshake; optionally decodes the switch/hex-display I/O location.

Parameters:
- WAIT_CYCLES, 2: SRAM access cycles (CE_N/OE_N or WE_N active) before R; legal 1..15.
- ADDR_W, 20: SRAM address width; the 16-bit MAR is zero-extended.
- IO_ADDR, 16'hFFFF: memory-mapped I/O address (used only with the optional feature).

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- MIO_EN  in  1  access request from control unit; held high until R seen
- R_W  in  1  1 = write, 0 = read; sampled at acceptance
- MAR  in  16  access address; sampled at acceptance
- MDR  in  16  write data; sampled at acceptance
- R  out  1  ready strobe, exactly one cycle per access
- MDR_In  out  16  read data, registered, valid when R=1 and held until next read completes
- ADDR  out  ADDR_W  SRAM address
- CE_N, OE_N, WE_N  out  1 each  SRAM controls, active-low
- Data_to_SRAM  out  16  write data
- Data_drive_en  out  1  enables the top-level tristate onto the SRAM data bus
- Data_from_SRAM  in  16  SRAM read bus
- S  in  16  switches (I/O read source)
- HEX_Out  out  16  hex display register (I/O write target)

Behaviour:
- Reset values: R=0, CE_N=OE_N=WE_N=1, Data_drive_en=0, MDR_In=0, ADDR=0, Data_to_SRAM=0, HEX_Out=0, state=IDLE, wait counter=0.
- A reset during any state returns to IDLE at that edge. WE_N/CE_N deassert the same edge and no partial write completes on the handshake.

FSM states:
- IDLE: if MIO_EN=1:
  - latch MAR (zero-extended to ADDR), R_W and MDR into Data_to_SRAM;
  - load counter with WAIT_CYCLES;
  - go to ACCESS (or IO when the feature applies).
- ACCESS:
  - CE_N=0.
  - Read: OE_N=0.
  - Write: WE_N=0 and Data_drive_en=1.
  - Counter decrements each cycle; on counter==1, capture Data_from_SRAM into MDR_In (reads only) and go to DONE.
- DONE:
  - R=1.
  - CE_N stays 0 on writes and Data_drive_en stays 1, giving one cycle of data hold. WE_N=1.
  - If MIO_EN=0, go to IDLE; otherwise go to RELEASE.
- RELEASE: all strobes inactive; wait until MIO_EN=0, then go to IDLE. This prevents a duplicate access if the control unit holds MIO_EN.

Timing and handshake rules:
- Latency: with MIO_EN first high in cycle 0, R=1 in cycle WAIT_CYCLES+1. For WAIT_CYCLES=2, R is high in cycle 3.
- R_W, MAR and MDR changes after acceptance are ignored.
- MIO_EN dropping during ACCESS does not abort the access; R still pulses.
- WE_N and OE_N are never low in the same cycle. Data_drive_en is never high on a read.
- Back-to-back accesses: MIO_EN low for one cycle (DONE→IDLE), then high again, starts a new access from IDLE with no extra gap.
- ADDR holds its last value between accesses.

Optional Feature:
- Macro: LC3_MEM_MMIO_EN.
- Defined: an access with MAR==IO_ADDR goes IDLE→IO→DONE and never touches SRAM (CE_N stays 1).
  - IO read: MDR_In<=S.
  - IO write: HEX_Out<=latched MDR.
  - R occurs in cycle 2 regardless of WAIT_CYCLES.
- Undefined: no decode; IO_ADDR is ordinary SRAM; HEX_Out is tied to 0 and S is unused.

Test Plan:
- Reset, then idle 5 cycles -> R=0, CE_N=OE_N=WE_N=1, Data_drive_en=0, MDR_In=0 throughout.
- Read with WAIT_CYCLES=2: MAR=16'h3000, R_W=0, SRAM model returns 16'hBEEF -> ADDR=20'h03000, OE_N=0 in cycles 1-2, R=1 only in cycle 3, MDR_In=16'hBEEF.
- Write: MAR=16'h0042, MDR=16'h1234, R_W=1 -> WE_N=0 exactly cycles 1-2, Data_to_SRAM=16'h1234 with Data_drive_en=1 in cycles 1-3, R pulse in cycle 3, SRAM model holds 16'h1234 at 16'h0042.
- Request held: MIO_EN kept high 6 cycles after R -> single access (one WE_N/OE_N burst), state RELEASE, returns to IDLE the cycle after MIO_EN falls.
- Reset mid-write: assert Reset in cycle 1 of write to 16'h0010 -> WE_N=1 and Data_drive_en=0 from next edge, no R, next read of 16'h0010 returns prior contents.
- With LC3_MEM_MMIO_EN: S=16'h00A5, read MAR=16'hFFFF -> R in cycle 2, MDR_In=16'h00A5, CE_N stays 1; write 16'h0C3D to 16'hFFFF -> HEX_Out=16'h0C3D.
